// File: rtl/sram2rw_port_arbiter.sv
// rtl/sram2rw_port_arbiter.sv - round-robin arbiter sharing one dual-port SRAM macro between NREQ requesters
module sram2rw_port_arbiter #(
   parameter int NREQ = 4,
   parameter int AW   = 4,
   parameter int DW   = 16
) (
   input  logic              CE,
   input  logic              RSTB,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ-1:0]    req_we,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]    rsp_valid,
   output logic [NREQ*DW-1:0] rsp_rdata,
   output logic [AW-1:0]      A1,
   output logic [AW-1:0]      A2,
   output logic               CSB1,
   output logic               CSB2,
   output logic               WEB1,
   output logic               WEB2,
   output logic               OEB1,
   output logic               OEB2,
   output logic [DW-1:0]      I1,
   output logic [DW-1:0]      I2,
   input  logic [DW-1:0]      O1,
   input  logic [DW-1:0]      O2
);

   localparam int IW = $clog2(NREQ);
   localparam logic [IW-1:0] LAST_ID = IW'(NREQ - 1);
   localparam logic [IW:0]   NREQ_W  = (IW + 1)'(NREQ);

   logic [AW-1:0] w_addr  [NREQ];
   logic [DW-1:0] w_wdata [NREQ];

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_addr[gi]  = req_addr[gi*AW +: AW];
      assign w_wdata[gi] = req_wdata[gi*DW +: DW];
   end

   logic [IW-1:0] r_rr_ptr;
   logic [IW-1:0] w_rr_next;
   logic [IW-1:0] w_last;
   logic [IW:0]   w_sum;
   logic [IW-1:0] w_idx;
   logic          w_hit1;
   logic          w_hit2;
   logic [IW-1:0] w_id1;
   logic [IW-1:0] w_id2;

   // Port 2 skips a candidate whose write would collide with the port-1 write.
   always_comb begin
      w_hit1 = 1'b0;
      w_hit2 = 1'b0;
      w_id1  = '0;
      w_id2  = '0;
      w_sum  = '0;
      w_idx  = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_sum = {1'b0, r_rr_ptr} + (IW + 1)'(k);
         if (w_sum >= NREQ_W) begin
            w_sum = w_sum - NREQ_W;
         end
         w_idx = w_sum[IW-1:0];
         if (req_valid[w_idx]) begin
            if (!w_hit1) begin
               w_hit1 = 1'b1;
               w_id1  = w_idx;
            end else if (!w_hit2 &&
                         !(req_we[w_idx] && req_we[w_id1] && (w_addr[w_idx] == w_addr[w_id1]))) begin
               w_hit2 = 1'b1;
               w_id2  = w_idx;
            end
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (w_hit1) begin
         req_ready[w_id1] = 1'b1;
      end
      if (w_hit2) begin
         req_ready[w_id2] = 1'b1;
      end
   end

   assign w_last    = w_hit2 ? w_id2 : w_id1;
   assign w_rr_next = (w_last == LAST_ID) ? '0 : w_last + 1'b1;

   logic          w_hit [2];
   logic [IW-1:0] w_gid [2];
   logic [DW-1:0] w_o   [2];

   assign w_hit[0] = w_hit1;
   assign w_hit[1] = w_hit2;
   assign w_gid[0] = w_id1;
   assign w_gid[1] = w_id2;
   assign w_o[0]   = O1;
   assign w_o[1]   = O2;

   logic          r_csb [2];
   logic          r_web [2];
   logic          r_oeb [2];
   logic [AW-1:0] r_a   [2];
   logic [DW-1:0] r_i   [2];
   logic          r_rd  [2];
   logic [IW-1:0] r_id  [2];
   logic          r_rv  [2];
   logic [IW-1:0] r_rid [2];

   // Stage 1 holds macro commands; stage 2 tracks reads whose data appears on O1/O2.
   always_ff @(posedge CE or negedge RSTB) begin
      if (!RSTB) begin
         r_rr_ptr <= '0;
         for (int p = 0; p < 2; p++) begin
            r_csb[p] <= 1'b1;
            r_web[p] <= 1'b1;
            r_oeb[p] <= 1'b1;
            r_a[p]   <= '0;
            r_i[p]   <= '0;
            r_rd[p]  <= 1'b0;
            r_id[p]  <= '0;
            r_rv[p]  <= 1'b0;
            r_rid[p] <= '0;
         end
      end else begin
         if (w_hit1) begin
            r_rr_ptr <= w_rr_next;
         end
         for (int p = 0; p < 2; p++) begin
            r_rv[p]  <= r_rd[p];
            r_rid[p] <= r_id[p];
            r_rd[p]  <= w_hit[p] & ~req_we[w_gid[p]];
            r_id[p]  <= w_gid[p];
            r_csb[p] <= ~w_hit[p];
            if (w_hit[p]) begin
               r_a[p]   <= w_addr[w_gid[p]];
               r_web[p] <= ~req_we[w_gid[p]];
               r_oeb[p] <= req_we[w_gid[p]];
               if (req_we[w_gid[p]]) begin
                  r_i[p] <= w_wdata[w_gid[p]];
               end
            end else begin
               r_web[p] <= 1'b1;
               r_oeb[p] <= 1'b1;
            end
         end
      end
   end

   assign CSB1 = r_csb[0];
   assign CSB2 = r_csb[1];
   assign WEB1 = r_web[0];
   assign WEB2 = r_web[1];
   assign OEB1 = r_oeb[0];
   assign OEB2 = r_oeb[1];
   assign A1   = r_a[0];
   assign A2   = r_a[1];
   assign I1   = r_i[0];
   assign I2   = r_i[1];

   always_comb begin
      rsp_valid = '0;
      rsp_rdata = '0;
      for (int p = 0; p < 2; p++) begin
         if (r_rv[p]) begin
            rsp_valid[r_rid[p]]            = 1'b1;
            rsp_rdata[r_rid[p]*DW +: DW]   = w_o[p];
         end
      end
   end

endmodule
